// File: rtl/text_pkg.sv
// Shared definitions for the text-overlay blocks: ASCII constants, the
// conversion FSM state type and small arithmetic helpers.
package text_pkg;

  localparam logic [7:0] CHAR_SPACE = 8'h20;
  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_NINE  = 8'h39;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FORMAT
  } conv_state_t;

  // Double-dabble correction: a digit that would reach 10 after doubling is pre-biased by 3.
  function automatic logic [3:0] bcd_add3(input logic [3:0] nibble);
    return (nibble >= 4'd5) ? (nibble + 4'd3) : nibble;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/score_to_chars_bcd_adjust.sv
// Combinational add-3 step applied to every BCD digit before each
// double-dabble shift.
module bcd_adjust
  import text_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [DIGITS*4-1:0] bcd_i,
  output logic [DIGITS*4-1:0] bcd_o
);

  always_comb begin
    bcd_o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      bcd_o[i*4 +: 4] = bcd_add3(bcd_i[i*4 +: 4]);
    end
  end

endmodule

// File: rtl/score_to_chars.sv
// Sequential binary-to-ASCII converter feeding the text overlay; one bit per
// clock, with leading-zero blanking, saturation and a one-deep request queue.
module score_to_chars
  import text_pkg::*;
#(
  parameter int VALUE_W     = 10,
  parameter int DIGITS      = 4,
  parameter bit BLANK_ZEROS = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [VALUE_W-1:0]      value_in,
  input  logic                    update,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic [DIGITS-1:0][7:0]  chars
);

  localparam int              BCD_W = DIGITS * 4;
  localparam int              CNT_W = $clog2(VALUE_W + 1);
  localparam longint unsigned MAX   = pow10(DIGITS) - 64'd1;

  typedef logic [DIGITS-1:0][7:0] chars_t;

  function automatic chars_t resetChars();
    chars_t r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i] = (BLANK_ZEROS && (i != DIGITS - 1)) ? CHAR_SPACE : CHAR_ZERO;
    end
    return r;
  endfunction

  localparam chars_t RESET_CHARS = resetChars();

  conv_state_t        stateQ, stateD;
  logic [VALUE_W-1:0] binQ, binD;
  logic [VALUE_W-1:0] valueQ, valueD;
  logic [VALUE_W-1:0] pendValQ, pendValD;
  logic [BCD_W-1:0]   bcdQ, bcdD;
  logic [CNT_W-1:0]   cntQ, cntD;
  logic               pendQ, pendD;
  logic               doneQ, doneD;
  logic               ovfQ, ovfD;
  chars_t             charsQ, charsD;

  logic [BCD_W-1:0]   bcdAdj;
  chars_t             fmtChars;
  logic               ovfNow;
  logic               leading;
  logic               doLoad;
  logic [VALUE_W-1:0] loadValue;
  logic [3:0]         nib;

  bcd_adjust #(.DIGITS(DIGITS)) u_adjust (
    .bcd_i (bcdQ),
    .bcd_o (bcdAdj)
  );

  // Overflow is judged on the original value, not the BCD result, whose top carries are lost.
  assign ovfNow = (64'(valueQ) > MAX);

  always_comb begin
    fmtChars = '0;
    leading  = BLANK_ZEROS;
    nib      = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nib = bcdQ[(DIGITS-1-i)*4 +: 4];
      if (ovfNow) begin
        fmtChars[i] = CHAR_NINE;
      end else if (leading && (nib == 4'd0) && (i != DIGITS - 1)) begin
        fmtChars[i] = CHAR_SPACE;
      end else begin
        fmtChars[i] = CHAR_ZERO + {4'd0, nib};
        leading     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ   <= IDLE;
      binQ     <= '0;
      valueQ   <= '0;
      pendValQ <= '0;
      bcdQ     <= '0;
      cntQ     <= '0;
      pendQ    <= 1'b0;
      doneQ    <= 1'b0;
      ovfQ     <= 1'b0;
      charsQ   <= RESET_CHARS;
    end else begin
      stateQ   <= stateD;
      binQ     <= binD;
      valueQ   <= valueD;
      pendValQ <= pendValD;
      bcdQ     <= bcdD;
      cntQ     <= cntD;
      pendQ    <= pendD;
      doneQ    <= doneD;
      ovfQ     <= ovfD;
      charsQ   <= charsD;
    end
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE:    if (update) stateD = SHIFT;
      SHIFT:   if (cntQ == CNT_W'(1)) stateD = FORMAT;
      FORMAT:  stateD = (update || pendQ) ? SHIFT : IDLE;
      default: stateD = IDLE;
    endcase
  end

  // A request arriving during FORMAT is taken directly so busy never dips.
  always_comb begin
    binD      = binQ;
    valueD    = valueQ;
    pendValD  = pendValQ;
    bcdD      = bcdQ;
    cntD      = cntQ;
    pendD     = pendQ;
    doneD     = 1'b0;
    ovfD      = ovfQ;
    charsD    = charsQ;
    doLoad    = 1'b0;
    loadValue = value_in;
    unique case (stateQ)
      IDLE: doLoad = update;
      SHIFT: begin
        {bcdD, binD} = {bcdAdj[BCD_W-2:0], binQ, 1'b0};
        cntD         = cntQ - CNT_W'(1);
        if (update) begin
          pendD    = 1'b1;
          pendValD = value_in;
        end
      end
      FORMAT: begin
        charsD = fmtChars;
        ovfD   = ovfNow;
        doneD  = 1'b1;
        if (update || pendQ) begin
          doLoad    = 1'b1;
          loadValue = update ? value_in : pendValQ;
          pendD     = 1'b0;
        end
      end
      default: ;
    endcase
    if (doLoad) begin
      binD   = loadValue;
      valueD = loadValue;
      bcdD   = '0;
      cntD   = CNT_W'(VALUE_W);
    end
  end

  always_comb begin
    busy     = (stateQ != IDLE) || pendQ;
    done     = doneQ;
    overflow = ovfQ;
    chars    = charsQ;
  end

endmodule

// File: tb/tb_score_to_chars.sv
// Drives three configurations of score_to_chars with the same request stream
// and compares them each cycle against a string-formatting reference model.
module tb_score_to_chars;

  logic       clk;
  logic       rst;
  logic [9:0] valueIn;
  logic       update;

  logic            busyA, doneA, ovfA;
  logic [3:0][7:0] charsA;
  logic            busyB, doneB, ovfB;
  logic [3:0][7:0] charsB;
  logic            busyC, doneC, ovfC;
  logic [2:0][7:0] charsC;

  int checks = 0;
  int errors = 0;
  int shownValue = 0;

  score_to_chars #(.VALUE_W(10), .DIGITS(4), .BLANK_ZEROS(1'b1)) dutA (
    .clk(clk), .rst(rst), .value_in(valueIn), .update(update),
    .busy(busyA), .done(doneA), .overflow(ovfA), .chars(charsA)
  );

  score_to_chars #(.VALUE_W(10), .DIGITS(4), .BLANK_ZEROS(1'b0)) dutB (
    .clk(clk), .rst(rst), .value_in(valueIn), .update(update),
    .busy(busyB), .done(doneB), .overflow(ovfB), .chars(charsB)
  );

  score_to_chars #(.VALUE_W(10), .DIGITS(3), .BLANK_ZEROS(1'b1)) dutC (
    .clk(clk), .rst(rst), .value_in(valueIn), .update(update),
    .busy(busyC), .done(doneC), .overflow(ovfC), .chars(charsC)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal text padded on the left, or all nines when it does not fit.
  function automatic logic [31:0] refChars(input int v, input int digits, input bit blank);
    logic [31:0] r;
    string       s;
    string       pad;
    int          maxv;
    maxv = 1;
    for (int k = 0; k < digits; k++) maxv = maxv * 10;
    maxv = maxv - 1;
    r = '0;
    if (v > maxv) begin
      for (int i = 0; i < digits; i++) r[i*8 +: 8] = 8'h39;
    end else begin
      s   = $sformatf("%0d", v);
      pad = blank ? " " : "0";
      while (s.len() < digits) s = {pad, s};
      for (int i = 0; i < digits; i++) r[i*8 +: 8] = s[i];
    end
    return r;
  endfunction

  function automatic logic refOvf(input int v, input int digits);
    int maxv;
    maxv = 1;
    for (int k = 0; k < digits; k++) maxv = maxv * 10;
    return (v > maxv - 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input bit busyExp, input bit doneExp);
    checkOutput({tag, " busyA"}, 32'(busyA), 32'(busyExp));
    checkOutput({tag, " doneA"}, 32'(doneA), 32'(doneExp));
    checkOutput({tag, " ovfA"},  32'(ovfA),  32'(refOvf(shownValue, 4)));
    checkOutput({tag, " charsA"}, 32'(charsA), refChars(shownValue, 4, 1'b1));
    checkOutput({tag, " busyB"}, 32'(busyB), 32'(busyExp));
    checkOutput({tag, " doneB"}, 32'(doneB), 32'(doneExp));
    checkOutput({tag, " ovfB"},  32'(ovfB),  32'(refOvf(shownValue, 4)));
    checkOutput({tag, " charsB"}, 32'(charsB), refChars(shownValue, 4, 1'b0));
    checkOutput({tag, " busyC"}, 32'(busyC), 32'(busyExp));
    checkOutput({tag, " doneC"}, 32'(doneC), 32'(doneExp));
    checkOutput({tag, " ovfC"},  32'(ovfC),  32'(refOvf(shownValue, 3)));
    checkOutput({tag, " charsC"}, 32'(charsC), refChars(shownValue, 3, 1'b1));
  endtask

  task automatic applyStimulus(input int v);
    valueIn = 10'(v);
    update  = 1'b1;
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  task automatic runConversion(input int v);
    applyStimulus(v);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) update = 1'b0;
      if (k == 12) shownValue = v;
      checkAll($sformatf("conv%0d k%0d", v, k), (k != 12), (k == 12));
    end
  endtask

  initial begin
    rst     = 1'b1;
    update  = 1'b0;
    valueIn = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkAll("reset", 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checkAll($sformatf("idle%0d", i), 1'b0, 1'b0);
    end

    runConversion(123);
    runConversion(0);
    runConversion(7);
    runConversion(1023);
    runConversion(999);
    runConversion(1000);
    runConversion(10);

    $display("[TB] overlapping requests");
    applyStimulus(45);
    for (int k = 1; k <= 23; k++) begin
      @(negedge clk);
      if (k == 12) shownValue = 45;
      if (k == 23) shownValue = 9;
      checkAll($sformatf("overlap k%0d", k), (k != 23), (k == 12 || k == 23));
      update = 1'b0;
      if (k == 3) applyStimulus(600);
      if (k == 5) applyStimulus(9);
    end

    $display("[TB] reset during conversion");
    applyStimulus(512);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      update = 1'b0;
      checkAll($sformatf("abort k%0d", k), 1'b1, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    shownValue = 0;
    checkAll("post reset", 1'b0, 1'b0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checkAll($sformatf("post reset idle%0d", i), 1'b0, 1'b0);
    end
    runConversion(512);

    $display("[TB] random values");
    for (int i = 0; i < 20; i++) begin
      runConversion(int'($urandom_range(0, 1023)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) begin
          @(negedge clk);
          checkAll("random gap", 1'b0, 1'b0);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
